// File: rtl/icache_lite_if.sv
// Fetch-side and refill-bus signals of icache_lite, grouped so the cache and
// its environment connect through one bundle.
interface icache_lite_if;
  logic        ioMem_ren;
  logic [31:0] ioMem_addr;
  logic        ioMem_hit;
  logic [63:0] ioMem_rData;
  logic        ioMem_rvalid;
  logic        flush;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  modport slave (
    input  ioMem_ren, ioMem_addr, flush, bus_gnt, bus_rvalid, bus_rdata,
    output ioMem_hit, ioMem_rData, ioMem_rvalid, bus_req, bus_addr
  );

  modport master (
    output ioMem_ren, ioMem_addr, flush, bus_gnt, bus_rvalid, bus_rdata,
    input  ioMem_hit, ioMem_rData, ioMem_rvalid, bus_req, bus_addr
  );
endinterface

// File: rtl/icache_lite.sv
// Direct-mapped, read-only instruction cache with 64-bit lines, a single
// outstanding refill and fence.i-style flush.
module icache_lite #(
  parameter int NUM_LINES = 16
) (
  input  logic          clock,
  input  logic          reset,
  icache_lite_if.slave  io,
  output logic          busy,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 29 - IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  logic [1:0]           state_r;
  logic [NUM_LINES-1:0] valid_r;
  logic                 flush_pend_r;
  logic                 bus_req_r;
  logic [31:0]          bus_addr_r;
  logic [63:0]          rdata_r;
  logic                 rvalid_r;
  logic [31:0]          hit_cnt_r;
  logic [31:0]          miss_cnt_r;

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [63:0]          data_mem [NUM_LINES];

  logic [IDX_W-1:0]     req_idx_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic [IDX_W-1:0]     fill_idx_s;
  logic [TAG_W-1:0]     fill_tag_s;
  logic                 hit_s;
  logic                 fill_s;

  assign req_idx_s  = io.ioMem_addr[3 +: IDX_W];
  assign req_tag_s  = io.ioMem_addr[31 -: TAG_W];
  // The latched refill address doubles as the line index/tag being filled.
  assign fill_idx_s = bus_addr_r[3 +: IDX_W];
  assign fill_tag_s = bus_addr_r[31 -: TAG_W];
  assign fill_s     = (state_r == ST_WAIT) && io.bus_rvalid;

  // Lookup: only an idle cache without a concurrent flush can hit.
  always_comb begin
    hit_s = 1'b0;
    if ((state_r == ST_IDLE) && io.ioMem_ren && !io.flush &&
        valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Control FSM, valid bits, refill request, returned data and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      valid_r      <= '0;
      flush_pend_r <= 1'b0;
      bus_req_r    <= 1'b0;
      bus_addr_r   <= 32'd0;
      rdata_r      <= 64'd0;
      rvalid_r     <= 1'b0;
      hit_cnt_r    <= 32'd0;
      miss_cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (io.flush) begin
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
          end else if (hit_s) begin
            rdata_r   <= data_mem[req_idx_s];
            hit_cnt_r <= sat_inc(hit_cnt_r);
          end else if (io.ioMem_ren) begin
            bus_req_r  <= 1'b1;
            bus_addr_r <= io.ioMem_addr & 32'hFFFF_FFF8;
            miss_cnt_r <= sat_inc(miss_cnt_r);
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (io.flush) begin
            flush_pend_r <= 1'b1;
          end
          if (io.bus_gnt) begin
            bus_req_r <= 1'b0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (io.flush) begin
            flush_pend_r <= 1'b1;
          end
          if (io.bus_rvalid) begin
            valid_r[fill_idx_s] <= 1'b1;
            rdata_r             <= io.bus_rdata;
            rvalid_r            <= 1'b1;
            state_r             <= ST_FILL;
          end
        end
        ST_FILL: begin
          rvalid_r <= 1'b0;
          state_r  <= ST_IDLE;
          // A flush seen during the refill wipes everything, the new line included.
          if (flush_pend_r || io.flush) begin
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_r <= 1'b0;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line tag/data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (fill_s) begin
      tag_mem[fill_idx_s]  <= fill_tag_s;
      data_mem[fill_idx_s] <= io.bus_rdata;
    end
  end

  assign io.ioMem_hit    = hit_s;
  assign io.ioMem_rData  = rdata_r;
  assign io.ioMem_rvalid = rvalid_r;
  assign io.bus_req      = bus_req_r;
  assign io.bus_addr     = bus_addr_r;
  assign busy            = (state_r != ST_IDLE);
  assign hit_cnt         = hit_cnt_r;
  assign miss_cnt        = miss_cnt_r;

endmodule

// File: doc/icache_lite.md
ICACHE_LITE -- requirements
Module: icache_lite

Interface
REQ-001 Parameter: NUM_LINES, 16, number of direct-mapped 64-bit lines; power of two, 2..256; IDX_W = log2(NUM_LINES).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ioMem_ren  input  1  fetch request from the fetch stage, valid for one cycle.
REQ-005 ioMem_addr  input  32  fetch address; bits [2:0] ignored (8-byte aligned).
REQ-006 ioMem_hit  output  1  combinational: request hits a valid line this cycle.
REQ-007 ioMem_rData  output  64  registered line data returned for the last serviced request.
REQ-008 ioMem_rvalid  output  1  registered one-cycle pulse: miss refill completed, rData updated.
REQ-009 flush  input  1  one-cycle request to invalidate all lines (fence.i).
REQ-010 bus_req  output  1  registered refill request to backing memory.
REQ-011 bus_addr  output  32  refill address {ioMem_addr[31:3],3'b0}, held while bus_req=1.
REQ-012 bus_gnt  input  1  backing memory accepts request when bus_req && bus_gnt.
REQ-013 bus_rvalid  input  1  refill data valid, one cycle.
REQ-014 bus_rdata  input  64  refill data.
REQ-015 busy  output  1  state != IDLE.
REQ-016 hit_cnt, miss_cnt  output  32 each  saturating performance counters.

Function
REQ-017 Address split: index = addr[3+IDX_W-1:3]; tag = addr[31:3+IDX_W]; storage per line: valid bit, tag, 64-bit data.
REQ-018 States: IDLE, REQ, WAIT, FILL; one-hot or binary encoding free.
REQ-019 IDLE: ioMem_hit = ioMem_ren && valid[index] && tag match && !flush; else 0; hit is 0 in all other states.
REQ-020 IDLE hit: at that edge ioMem_rData <= line data, hit_cnt += 1; state stays IDLE; no rvalid pulse.
REQ-021 IDLE miss (ren && !hit && !flush): latch address, bus_req <= 1, bus_addr <= aligned address, miss_cnt += 1, go REQ.
REQ-022 REQ: hold bus_req/bus_addr; on bus_gnt: bus_req <= 0, go WAIT.
REQ-023 WAIT: on bus_rvalid: write line (valid=1, tag, data=bus_rdata), ioMem_rData <= bus_rdata, ioMem_rvalid <= 1, go FILL.
REQ-024 FILL: single cycle; rvalid returns to 0; go IDLE; ren during FILL ignored (hit=0).
REQ-025 Minimum miss latency: request in cycle 0, gnt in cycle 1, bus_rvalid in cycle 2 -> rvalid high in cycle 3.
REQ-026 ren in REQ/WAIT/FILL ignored; no queuing; requester waits for rvalid before new request.
REQ-027 ioMem_rData holds its value until the next hit or refill; never changes otherwise.
REQ-028 bus_rvalid outside WAIT ignored; bus_gnt outside REQ ignored.
REQ-029 flush in IDLE: all valid bits cleared at that edge; simultaneous ren treated as miss-free no-op (hit=0, no refill started).
REQ-030 flush in REQ/WAIT/FILL: recorded as pending; refill completes and returns data normally, but all valid bits (including refilled line) cleared on entry to IDLE.
REQ-031 Counters saturate at 0xFFFFFFFF; never wrap.
REQ-032 Refill to an index with a valid line of different tag overwrites it (no victim writeback; read-only cache).

Reset
REQ-033 On reset assertion, immediately: state IDLE, all valid bits 0, pending flush 0, bus_req 0, bus_addr 0, ioMem_rData 0, ioMem_rvalid 0, counters 0.
REQ-034 Reset mid-refill abandons the refill; no line written; bus_rvalid after deassertion in IDLE ignored.
REQ-035 Line data/tag arrays need no reset.

Verification
REQ-036 Cold miss: NUM_LINES=16, ren addr 0x80000000, gnt next cycle, bus_rdata 0x00000413_00000297 one cycle later -> hit=0, bus_addr 0x80000000, rvalid pulse, rData 0x0000041300000297, miss_cnt=1.
REQ-037 Warm hit: repeat addr 0x80000004 -> hit=1 same cycle, rData 0x0000041300000297 next cycle, no bus_req, hit_cnt=1.
REQ-038 Conflict: ren 0x80000080 (same index 0, new tag) -> miss, refill overwrites; then 0x80000000 -> miss again, miss_cnt=3.
REQ-039 Flush: hit on 0x80000000, pulse flush in IDLE, ren 0x80000000 -> hit=0, refill issued; flush during WAIT -> rvalid delivered, next ren same address misses.
REQ-040 Stalled grant: hold bus_gnt=0 for 5 cycles -> bus_req and bus_addr stable throughout, ren pulses ignored, busy=1.
REQ-041 Async reset asserted in WAIT between clock edges -> bus_req, rvalid, busy 0 immediately; later ren to same address misses.
